// File: rtl/fir_job_scheduler.sv
// fir_job_scheduler
//   Sequences the work issued to the FIR filter core. It sits between the
//   AHB-Lite slave register block and the FIR datapath.
//   - Coefficient-set request: walks F0..F(NUM_COEFFS-1) into the core one at a
//     time, waiting on modwait after each load.
//   - Sample request: issues one computation and records err at completion.
//   - The two request types are arbitrated so they never overlap. Coefficient
//     loads win ties, and a job is never preempted.
//   - A watchdog parks the scheduler in FAULT when the core hangs in a wait.
//
// Ports
//   clk, n_rst           rising-edge clock, async active-low reset
//   new_coefficient_set  level from slave: coefficient load pending
//   data_ready           level from slave: sample pending
//   modwait, err         FIR core busy / error flags
//   clear_fault          one-cycle pulse: leave FAULT
//   load_coeff           pulse: core loads slot coefficient_num
//   coefficient_num      coefficient index (idx register)
//   start_sample         pulse: core starts a computation
//   sample_ack           pulse to slave: clear data_ready
//   coeff_clear          pulse to slave: clear new_coefficient_set
//   busy                 scheduler not IDLE
//   timeout_err          sticky watchdog flag, cleared by clear_fault
//   sample_err           err captured when the last sample job completed
//
// Every output comes from a flop. The issue pulses are registered from the
// next-state decode, so a pulse is high exactly while its state is occupied.
module fir_job_scheduler #(
  parameter int NUM_COEFFS     = 4,
  parameter int CNUM_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  new_coefficient_set,
  input  logic                  data_ready,
  input  logic                  modwait,
  input  logic                  err,
  input  logic                  clear_fault,
  output logic                  load_coeff,
  output logic [CNUM_WIDTH-1:0] coefficient_num,
  output logic                  start_sample,
  output logic                  sample_ack,
  output logic                  coeff_clear,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  sample_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNUM_WIDTH-1:0] IDX_LAST = CNUM_WIDTH'(NUM_COEFFS - 1);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_ISSUE,
    LOAD_BLANK,
    LOAD_WAIT,
    COEFF_DONE,
    SAMPLE_ISSUE,
    SAMPLE_BLANK,
    SAMPLE_WAIT,
    FAULT
  } state_t;

  state_t                state, nxt;
  logic [CNUM_WIDTH-1:0] idx, idx_nxt;
  logic [WD_W-1:0]       wd_cnt;
  logic                  wd_expired;
  logic                  in_wait;

  // wd_cnt counts the cycles spent waiting with modwait high. On the last
  // allowed cycle, a modwait that is still high sends the FSM to FAULT.
  assign wd_expired = (wd_cnt == WD_LAST);
  assign in_wait    = (state == LOAD_WAIT) || (state == SAMPLE_WAIT);

  // coefficient_num is the idx register itself. It therefore stays stable
  // across ISSUE/BLANK/WAIT, and it reads 0 in IDLE because every path back to
  // IDLE clears idx.
  assign coefficient_num = idx;

  always_comb begin
    nxt     = state;
    idx_nxt = idx;
    unique case (state)
      IDLE: begin
        if (new_coefficient_set)  nxt = LOAD_ISSUE;
        else if (data_ready)      nxt = SAMPLE_ISSUE;
      end
      LOAD_ISSUE:   nxt = LOAD_BLANK;
      // The core needs one cycle to raise modwait, so it is not looked at here.
      LOAD_BLANK:   nxt = LOAD_WAIT;
      LOAD_WAIT: begin
        if (modwait) begin
          if (wd_expired) nxt = FAULT;
        end else if (idx == IDX_LAST) begin
          nxt = COEFF_DONE;
        end else begin
          idx_nxt = idx + 1'b1;
          nxt     = LOAD_ISSUE;
        end
      end
      COEFF_DONE: begin
        nxt     = IDLE;
        idx_nxt = '0;
      end
      SAMPLE_ISSUE: nxt = SAMPLE_BLANK;
      SAMPLE_BLANK: nxt = SAMPLE_WAIT;
      SAMPLE_WAIT: begin
        if (modwait) begin
          if (wd_expired) nxt = FAULT;
        end else begin
          nxt = IDLE;
        end
      end
      // Leaving FAULT abandons a partial load. new_coefficient_set is still
      // high, so the next load restarts from F0.
      FAULT: begin
        if (clear_fault) begin
          nxt     = IDLE;
          idx_nxt = '0;
        end
      end
      default: begin
        nxt     = IDLE;
        idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      idx          <= '0;
      wd_cnt       <= '0;
      load_coeff   <= 1'b0;
      start_sample <= 1'b0;
      sample_ack   <= 1'b0;
      coeff_clear  <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      sample_err   <= 1'b0;
    end else begin
      state <= nxt;
      idx   <= idx_nxt;

      // Any state change restarts the watchdog.
      if (nxt != state)          wd_cnt <= '0;
      else if (in_wait && modwait) wd_cnt <= wd_cnt + 1'b1;

      load_coeff   <= (nxt == LOAD_ISSUE);
      start_sample <= (nxt == SAMPLE_ISSUE);
      sample_ack   <= (nxt == SAMPLE_ISSUE);
      coeff_clear  <= (nxt == COEFF_DONE);
      busy         <= (nxt != IDLE);

      if (state != FAULT && nxt == FAULT)      timeout_err <= 1'b1;
      else if (state == FAULT && nxt == IDLE)  timeout_err <= 1'b0;

      if (state == SAMPLE_WAIT && nxt == IDLE) sample_err <= err;
    end
  end

endmodule

// File: tb/tb_fir_job_scheduler.sv
// Self-checking bench for fir_job_scheduler.
// The reference model tracks jobs by time: an issue at cycle t whose core busy
// time is D cycles is followed by the next step at t + max(3, D+2). The
// watchdog trips at t + 66 once modwait stays high through the whole window.
module tb_fir_job_scheduler;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int TO = 64;

  logic          tb_clk = 1'b0;
  logic          n_rst;
  logic          new_coefficient_set, data_ready, modwait, err, clear_fault;
  logic          load_coeff, start_sample, sample_ack, coeff_clear;
  logic          busy, timeout_err, sample_err;
  logic [CW-1:0] coefficient_num;

  always #5 tb_clk = ~tb_clk;

  fir_job_scheduler #(.NUM_COEFFS(NC), .CNUM_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(tb_clk), .n_rst(n_rst),
    .new_coefficient_set(new_coefficient_set), .data_ready(data_ready),
    .modwait(modwait), .err(err), .clear_fault(clear_fault),
    .load_coeff(load_coeff), .coefficient_num(coefficient_num),
    .start_sample(start_sample), .sample_ack(sample_ack),
    .coeff_clear(coeff_clear), .busy(busy),
    .timeout_err(timeout_err), .sample_err(sample_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model: mode 0 idle, 1 loading, 2 coeff done, 3 sample, 4 fault
  int m_mode, m_t0, m_next, m_fault_at, m_k;
  bit m_terr, m_serr;
  int force_d = -1;
  int stuck_k = -1;
  int mw_from = 0, mw_until = -1;
  logic p_ncs, p_dr, p_err, p_clr, p_rst;
  int lc_cnt = 0, cc_cnt = 0, ss_cnt = 0, last_lc = 0, last_cc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_terr = 0; m_serr = 0;
    m_t0 = -100; m_next = -1; m_fault_at = -1;
    mw_from = 0; mw_until = -1;
  endtask

  // Begin an issue at cycle n and let the FIR model decide how long it stays busy.
  task automatic start_job(input int n, input bit is_load);
    int d;
    d = (force_d >= 0) ? force_d : int'($urandom_range(0, 8));
    if (is_load && m_k == stuck_k) d = 100000;
    m_t0       = n;
    m_next     = n + ((d + 2 > 3) ? d + 2 : 3);
    m_fault_at = (d >= TO + 1) ? n + TO + 2 : -1;
    mw_from    = n + 1;
    mw_until   = n + d;
  endtask

  task automatic model_step(input int n);
    if (!p_rst) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (p_ncs) begin m_mode = 1; m_k = 0; start_job(n, 1'b1); end
         else if (p_dr) begin m_mode = 3; m_k = 0; start_job(n, 1'b0); end
      1: if (n == m_fault_at) begin m_mode = 4; m_terr = 1; end
         else if (n == m_next) begin
           if (m_k == NC - 1) m_mode = 2;
           else begin m_k++; start_job(n, 1'b1); end
         end
      2: begin m_mode = 0; m_k = 0; end
      3: if (n == m_fault_at) begin m_mode = 4; m_terr = 1; end
         else if (n == m_next) begin m_mode = 0; m_serr = p_err; end
      4: if (p_clr) begin m_mode = 0; m_terr = 0; m_k = 0; end
      default: m_mode = 0;
    endcase
  endtask

  // Advance one clock. Outputs are checked 1 time unit after the edge, and
  // then the core/slave models react within the same cycle.
  task automatic tick();
    p_ncs = new_coefficient_set; p_dr = data_ready; p_err = err;
    p_clr = clear_fault; p_rst = n_rst;
    @(posedge tb_clk); #1;
    cyc++;
    model_step(cyc);
    chk("load_coeff",      32'(load_coeff),      32'(m_mode == 1 && cyc == m_t0));
    chk("coefficient_num", 32'(coefficient_num), 32'(m_k));
    chk("start_sample",    32'(start_sample),    32'(m_mode == 3 && cyc == m_t0));
    chk("sample_ack",      32'(sample_ack),      32'(m_mode == 3 && cyc == m_t0));
    chk("coeff_clear",     32'(coeff_clear),     32'(m_mode == 2));
    chk("busy",            32'(busy),            32'(m_mode != 0));
    chk("timeout_err",     32'(timeout_err),     32'(m_terr));
    chk("sample_err",      32'(sample_err),      32'(m_serr));
    lc_cnt += int'(load_coeff); cc_cnt += int'(coeff_clear); ss_cnt += int'(start_sample);
    if (load_coeff)  last_lc = cyc;
    if (coeff_clear) last_cc = cyc;
    modwait = (cyc >= mw_from && cyc <= mw_until);
    if (coeff_clear) new_coefficient_set = 1'b0;
    if (sample_ack)  data_ready = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (!busy) break;
    end
    if (i == budget) chk("idle_budget", 32'(busy), 32'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, p0, i;
    // Power-on reset with every input high.
    n_rst = 1'b0;
    new_coefficient_set = 1; data_ready = 1; modwait = 1; err = 1; clear_fault = 1;
    repeat (3) @(posedge tb_clk);
    #1;
    chk("rst_load_coeff",  32'(load_coeff), 0);
    chk("rst_cnum",        32'(coefficient_num), 0);
    chk("rst_start",       32'(start_sample), 0);
    chk("rst_ack",         32'(sample_ack), 0);
    chk("rst_cclear",      32'(coeff_clear), 0);
    chk("rst_busy",        32'(busy), 0);
    chk("rst_timeout",     32'(timeout_err), 0);
    chk("rst_sample_err",  32'(sample_err), 0);
    model_reset();
    new_coefficient_set = 0; data_ready = 0; modwait = 0; err = 0; clear_fault = 0;
    n_rst = 1'b1;
    repeat (5) tick();

    // Back-to-back coefficient load with no wait states.
    force_d = 0; lc_cnt = 0; cc_cnt = 0;
    new_coefficient_set = 1;
    tick(); t0 = cyc;
    run_idle(40);
    chk("load_to_idle", 32'(cyc - t0), 32'(3 * NC + 1));
    chk("load_pulses",  32'(lc_cnt), 32'(NC));
    chk("clear_pulses", 32'(cc_cnt), 1);

    // Sample with 5 busy cycles and err high at completion.
    force_d = 5; err = 1; data_ready = 1;
    tick(); t0 = cyc;
    chk("ss_ack_together", 32'({start_sample, sample_ack}), 32'(2'b11));
    run_idle(30);
    chk("sample_busy_drop", 32'(cyc - t0), 7);
    chk("sample_err_set",   32'(sample_err), 1);
    err = 0;

    // Both requests in the same cycle: the load runs to completion first.
    force_d = 1; lc_cnt = 0;
    new_coefficient_set = 1; data_ready = 1;
    tick(); t0 = cyc;
    for (i = 0; i < 40 && !start_sample; i++) tick();
    chk("both_load_first", 32'(cyc - t0), 32'(3 * NC + 2));
    chk("both_lc_count",   32'(lc_cnt), 32'(NC));
    run_idle(30);

    // data_ready raised mid-load is taken right after coeff_clear.
    new_coefficient_set = 1;
    repeat (5) tick();
    data_ready = 1;
    for (i = 0; i < 40 && !start_sample; i++) tick();
    chk("dr_after_clear", 32'(cyc - last_cc), 2);
    run_idle(30);

    // modwait sticks high while F2 is loading, so the watchdog fires.
    force_d = 0; stuck_k = 2;
    new_coefficient_set = 1;
    for (i = 0; i < 200 && !timeout_err; i++) tick();
    chk("wd_fault_time", 32'(cyc - last_lc), 32'(TO + 2));
    chk("wd_cnum_held",  32'(coefficient_num), 2);
    p0 = lc_cnt + cc_cnt + ss_cnt;
    repeat (10) tick();
    chk("fault_quiet", 32'(lc_cnt + cc_cnt + ss_cnt - p0), 0);
    stuck_k = -1; mw_until = -1; modwait = 0;
    clear_fault = 1;
    tick();
    clear_fault = 0;
    chk("fault_cleared", 32'(timeout_err), 0);
    tick();
    chk("reload_from_f0", 32'({load_coeff, coefficient_num}), 32'({1'b1, 2'd0}));
    run_idle(60);

    // Random traffic: random busy times, err and stray clear_fault pulses.
    force_d = -1;
    for (int r = 0; r < 600; r++) begin
      if (!new_coefficient_set && $urandom_range(0, 24) == 0) new_coefficient_set = 1;
      if (!data_ready && $urandom_range(0, 5) == 0) data_ready = 1;
      err = 1'($urandom_range(0, 1));
      clear_fault = ($urandom_range(0, 29) == 0);
      tick();
    end
    clear_fault = 0;
    for (i = 0; i < 20 && (new_coefficient_set || data_ready || busy); i++) run_idle(60);

    // Reset in LOAD_WAIT with idx=2: everything drops without a clock edge.
    force_d = 4;
    new_coefficient_set = 1;
    for (i = 0; i < 60 && !(m_mode == 1 && m_k == 2 && cyc == m_t0 + 2); i++) tick();
    chk("pre_rst_cnum", 32'(coefficient_num), 2);
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_cnum", 32'(coefficient_num), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_lc",   32'(load_coeff), 0);
    new_coefficient_set = 0; modwait = 0;
    model_reset();
    p0 = cc_cnt;
    tick();
    n_rst = 1'b1;
    repeat (6) tick();
    chk("no_clear_after_rst", 32'(cc_cnt - p0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
